// File: rtl/zeta_addr_sched_pkg.sv
// zeta_addr_sched_pkg: shared widths, FSM states and mode encodings for the zeta address scheduler.
`ifndef NTT_STAGE_CNT
`define NTT_STAGE_CNT 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package zeta_addr_sched_pkg;
    localparam int STAGE_CNT = `NTT_STAGE_CNT;
    typedef logic [STAGE_CNT-2:0] zeta_addr_t;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} state_t;
    localparam logic MODE_NTT  = 1'b0;
    localparam logic MODE_INTT = 1'b1;
endpackage

// File: rtl/zeta_addr_sched_if.sv
// zeta_addr_sched_if: job control, stage strobes and per-lane ROM address bus of the scheduler.
interface zeta_addr_sched_if #(
    parameter int NTT_STAGE_CNT = `NTT_STAGE_CNT,
    parameter int POLY_CNT_W    = 8
);
    logic                                          i_start;
    logic                                          i_mode;
    logic [POLY_CNT_W-1:0]                         i_num_poly;
    logic [NTT_STAGE_CNT-1:0]                      i_stage_adv;
    logic [1:0][NTT_STAGE_CNT-1:0][NTT_STAGE_CNT-2:0] o_rom_addr;
    logic                                          o_busy;
    logic                                          o_done;

    modport master (
        output i_start, i_mode, i_num_poly, i_stage_adv,
        input  o_rom_addr, o_busy, o_done
    );

    modport slave (
        input  i_start, i_mode, i_num_poly, i_stage_adv,
        output o_rom_addr, o_busy, o_done
    );
endinterface

// File: rtl/zeta_addr_sched_stage_cnt.sv
// zeta_stage_cnt: per-stage pair/poly counters and registered two-lane zeta address.
module zeta_stage_cnt import zeta_addr_sched_pkg::*; #(
    parameter int NTT_STAGE_CNT = `NTT_STAGE_CNT,
    parameter int POLY_CNT_W    = 8,
    parameter int STAGE         = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_run,
    input  logic                     i_clr,
    input  logic                     i_mode,
    input  logic                     i_adv,
    input  logic [POLY_CNT_W-1:0]    i_num_poly,
    output logic [NTT_STAGE_CNT-2:0] o_addr0,
    output logic [NTT_STAGE_CNT-2:0] o_addr1,
    output logic                     o_last
);
    localparam int AW = NTT_STAGE_CNT - 1;
    localparam int KW = NTT_STAGE_CNT - 2;
    localparam int SH = NTT_STAGE_CNT - 1 - STAGE;
    localparam logic [AW-1:0] MASK = AW'((1 << STAGE) - 1);
    localparam bit IS_LAST = (STAGE == NTT_STAGE_CNT - 1);

    logic [KW-1:0]         r_k;
    logic [POLY_CNT_W-1:0] r_poly;
    logic [AW-1:0]         r_addr0, r_addr1;
    logic [AW-1:0]         w_idx0, w_idx1, w_addr0, w_addr1;
    logic                  w_acc, w_wrap;

    // A stage that already finished every polynomial ignores further strobes.
    always_comb begin
        w_acc   = i_run && i_adv && (r_poly != i_num_poly);
        w_wrap  = &r_k;
        w_idx0  = {r_k, 1'b0} >> SH;
        w_idx1  = {r_k, 1'b1} >> SH;
        w_addr0 = (i_mode == MODE_INTT) ? ~w_idx0 & MASK : w_idx0;
        w_addr1 = (i_mode == MODE_INTT) ? ~w_idx1 & MASK : w_idx1;
        o_last  = IS_LAST && w_acc && w_wrap && (r_poly + POLY_CNT_W'(1) == i_num_poly);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_k     <= '0;
            r_poly  <= '0;
            r_addr0 <= '0;
            r_addr1 <= '0;
        end else if (i_clr) begin
            r_k    <= '0;
            r_poly <= '0;
        end else if (w_acc) begin
            r_addr0 <= w_addr0;
            r_addr1 <= w_addr1;
            r_k     <= r_k + KW'(1);
            if (w_wrap) r_poly <= r_poly + POLY_CNT_W'(1);
        end
    end

    assign o_addr0 = r_addr0;
    assign o_addr1 = r_addr1;
endmodule

// File: rtl/zeta_addr_sched.sv
// zeta_addr_sched: job FSM driving per-stage zeta ROM address generators for the NTT/INTT pipeline.
module zeta_addr_sched import zeta_addr_sched_pkg::*; #(
    parameter int NTT_STAGE_CNT = `NTT_STAGE_CNT,
    parameter int POLY_CNT_W    = 8
) (
    input logic               clk,
    input logic               rst_n,
    zeta_addr_sched_if.slave  bus
);
    state_t                                           r_state, w_next;
    logic                                             r_mode;
    logic [POLY_CNT_W-1:0]                            r_num_poly;
    logic                                             w_start_ok, w_run, w_fin;
    logic [NTT_STAGE_CNT-1:0]                         w_last_vec;
    logic [1:0][NTT_STAGE_CNT-1:0][NTT_STAGE_CNT-2:0] w_rom_addr;

    for (genvar s = 0; s < NTT_STAGE_CNT; s++) begin : g_stage
        zeta_stage_cnt #(
            .NTT_STAGE_CNT(NTT_STAGE_CNT),
            .POLY_CNT_W   (POLY_CNT_W),
            .STAGE        (s)
        ) u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_run     (w_run),
            .i_clr     (w_start_ok),
            .i_mode    (r_mode),
            .i_adv     (bus.i_stage_adv[s]),
            .i_num_poly(r_num_poly),
            .o_addr0   (w_rom_addr[0][s]),
            .o_addr1   (w_rom_addr[1][s]),
            .o_last    (w_last_vec[s])
        );
    end

    // Only the final stage can raise its last flag, so the OR is the job-complete event.
    always_comb begin
        w_run      = (r_state == ST_RUN);
        w_fin      = |w_last_vec;
        w_start_ok = (r_state == ST_IDLE) && bus.i_start && (bus.i_num_poly != '0);
        w_next     = w_start_ok                 ? ST_RUN   :
                     (w_run && w_fin)           ? ST_FLUSH :
                     (r_state == ST_FLUSH)      ? ST_IDLE  : r_state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_mode     <= MODE_NTT;
            r_num_poly <= '0;
        end else begin
            r_state <= w_next;
            if (w_start_ok) begin
                r_mode     <= bus.i_mode;
                r_num_poly <= bus.i_num_poly;
            end
        end
    end

    assign bus.o_rom_addr = w_rom_addr;
    assign bus.o_busy     = (r_state != ST_IDLE);
    assign bus.o_done     = (r_state == ST_FLUSH);
endmodule

// File: tb/tb_zeta_addr_sched.sv
// tb_zeta_addr_sched: scoreboard bench comparing ROM addresses, busy and done against a reference model.
module tb_zeta_addr_sched;
    localparam int NS = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    zeta_addr_sched_if #(.NTT_STAGE_CNT(NS), .POLY_CNT_W(8)) bus ();
    zeta_addr_sched #(.NTT_STAGE_CNT(NS), .POLY_CNT_W(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct { int s; int a0; int a1; } exp_t;
    exp_t q[$];
    int n_chk = 0;
    int n_err = 0;
    int n_done = 0;
    int m_state = 0;
    int m_mode = 0;
    int m_np = 0;
    int m_k[NS];
    int m_poly[NS];
    int m_a[2][NS];

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic int ea(input int s, input int k, input int lane, input int md);
        int idx;
        idx = (2 * k + lane) >> (NS - 1 - s);
        return (md != 0) ? ((1 << s) - 1 - idx) : idx;
    endfunction

    task automatic model_clear(input bit addr_too);
        for (int s = 0; s < NS; s++) begin
            m_k[s] = 0;
            m_poly[s] = 0;
            if (addr_too) begin
                m_a[0][s] = 0;
                m_a[1][s] = 0;
            end
        end
    endtask

    task automatic chk_img(input string tag);
        for (int l = 0; l < 2; l++)
            for (int s = 0; s < NS; s++)
                chk(tag, int'(bus.o_rom_addr[l][s]), m_a[l][s]);
    endtask

    task automatic step(input logic [NS-1:0] adv, input logic st = 1'b0, input logic md = 1'b0, input int np = 0);
        int nxt;
        exp_t e;
        bus.i_stage_adv = adv;
        bus.i_start = st;
        bus.i_mode = md;
        bus.i_num_poly = 8'(np);
        nxt = (m_state == 2) ? 0 : m_state;
        if (m_state == 1) begin
            for (int s = 0; s < NS; s++) begin
                if (adv[s] && m_poly[s] != m_np) begin
                    e.s = s;
                    e.a0 = ea(s, m_k[s], 0, m_mode);
                    e.a1 = ea(s, m_k[s], 1, m_mode);
                    q.push_back(e);
                    m_a[0][s] = e.a0;
                    m_a[1][s] = e.a1;
                    if (m_k[s] == 63) begin
                        m_k[s] = 0;
                        m_poly[s]++;
                        if (s == NS - 1 && m_poly[s] == m_np) nxt = 2;
                    end else begin
                        m_k[s]++;
                    end
                end
            end
        end
        if (m_state == 0 && st && np != 0) begin
            nxt = 1;
            m_mode = int'(md);
            m_np = np;
            model_clear(1'b0);
        end
        @(posedge clk);
        #1;
        m_state = nxt;
        while (q.size() > 0) begin
            e = q.pop_front();
            chk($sformatf("addr_l0_s%0d", e.s), int'(bus.o_rom_addr[0][e.s]), e.a0);
            chk($sformatf("addr_l1_s%0d", e.s), int'(bus.o_rom_addr[1][e.s]), e.a1);
        end
        chk("busy", int'(bus.o_busy), int'(m_state != 0));
        chk("done", int'(bus.o_done), int'(m_state == 2));
        if (bus.o_done) n_done++;
        bus.i_stage_adv = '0;
        bus.i_start = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            bus.i_stage_adv = NS'($urandom);
            bus.i_start = 1'b1;
            bus.i_mode = 1'($urandom_range(0, 1));
            bus.i_num_poly = 8'd3;
            @(posedge clk);
            #1;
            m_state = 0;
            model_clear(1'b1);
            q.delete();
            chk("rst_busy", int'(bus.o_busy), 0);
            chk("rst_done", int'(bus.o_done), 0);
            chk_img("rst_addr");
        end
        bus.i_start = 1'b0;
        bus.i_stage_adv = '0;
        rst_n = 1'b1;
    endtask

    initial begin
        bus.i_start = 1'b0;
        bus.i_mode = 1'b0;
        bus.i_num_poly = '0;
        bus.i_stage_adv = '0;
        do_reset(4);
        step('0);
        chk("start_in_rst_ignored", int'(bus.o_busy), 0);

        // NTT job, one polynomial: stage 1 boundary around k = 31/32
        step('0, 1'b1, 1'b0, 1);
        for (int i = 0; i < 32; i++) step(8'h02);
        chk("s1_k31_l0", int'(bus.o_rom_addr[0][1]), 0);
        chk("s1_k31_l1", int'(bus.o_rom_addr[1][1]), 0);
        step(8'h02);
        chk("s1_k32_l0", int'(bus.o_rom_addr[0][1]), 1);
        chk("s1_k32_l1", int'(bus.o_rom_addr[1][1]), 1);
        step(8'h02, 1'b1, 1'b1, 5);
        for (int i = 0; i < 30; i++) step(8'h02);
        step(8'h02);
        chk_img("s1_overrun_hold");
        for (int i = 0; i < 6; i++) step(8'h81);
        chk("ntt_s7_k5_l0", int'(bus.o_rom_addr[0][7]), 10);
        chk("ntt_s7_k5_l1", int'(bus.o_rom_addr[1][7]), 11);
        chk("ntt_s0_l0", int'(bus.o_rom_addr[0][0]), 0);
        chk("ntt_s0_l1", int'(bus.o_rom_addr[1][0]), 0);
        for (int i = 0; i < 58; i++) step(8'h80);
        chk("ntt_done", int'(bus.o_done), 1);
        step(8'h80);
        chk_img("flush_hold");
        step('0);

        // INTT job, reset at pair 20
        step('0, 1'b1, 1'b1, 1);
        for (int i = 0; i < 6; i++) step(8'h81);
        chk("intt_s7_k5_l0", int'(bus.o_rom_addr[0][7]), 117);
        chk("intt_s7_k5_l1", int'(bus.o_rom_addr[1][7]), 116);
        chk("intt_s0_l0", int'(bus.o_rom_addr[0][0]), 0);
        chk("intt_s0_l1", int'(bus.o_rom_addr[1][0]), 0);
        for (int i = 0; i < 14; i++) step(8'h81);
        n_done = 0;
        do_reset(2);
        step('0);
        step('0);
        chk("no_done_after_rst", n_done, 0);

        // zero-length job is rejected
        step('0, 1'b1, 1'b0, 0);
        step('0);
        chk("np0_idle", int'(bus.o_busy), 0);

        // two polynomials, every stage strobed each cycle
        n_done = 0;
        step('0, 1'b1, 1'b0, 2);
        step(8'hFF);
        chk("restart_s1_l0", int'(bus.o_rom_addr[0][1]), 0);
        chk("restart_s1_l1", int'(bus.o_rom_addr[1][1]), 0);
        for (int i = 0; i < 127; i++) step(8'hFF);
        chk("done_after_128", int'(bus.o_done), 1);
        step(8'h80);
        chk_img("final_extra_hold");
        step('0);
        chk("done_pulses", n_done, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
